// File: rtl/alu_sin_deserializer_if.sv
// Serial-in / decoded-out bundle between the ALU serial front-end and its neighbours.
// The master drives the bitstream and the slave (deserializer) drives the decoded results.
interface alu_sin_deserializer_if #(
  parameter int unsigned DATA_W = 32
);
  logic              sin;
  logic              out_valid;
  logic [DATA_W-1:0] out_b;
  logic [DATA_W-1:0] out_a;
  logic [2:0]        out_op;
  logic              err_valid;
  logic [2:0]        err_flags;

  modport master (
    output sin,
    input  out_valid, out_b, out_a, out_op, err_valid, err_flags
  );

  modport slave (
    input  sin,
    output out_valid, out_b, out_a, out_op, err_valid, err_flags
  );
endinterface

// File: rtl/alu_sin_deserializer.sv
// Serial front-end of the ALU: frames the sin bitstream into B/A operands and a command,
// checks frame count, CRC4 and opcode, then emits a one-cycle valid or error pulse.
module alu_sin_deserializer #(
  parameter int unsigned DATA_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  alu_sin_deserializer_if.slave bus
);
  localparam int unsigned NF = 2 * DATA_W / 8;
  localparam int unsigned CW = $clog2(NF + 2);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_TYPE,
    S_PAYLOAD,
    S_STOP
  } state_t;

  state_t              r_state;
  logic                r_is_cmd;
  logic [2:0]          r_bitcnt;
  logic [7:0]          r_byte;
  logic [2*DATA_W-1:0] r_sh;
  logic [CW-1:0]       r_cnt;
  logic [3:0]          r_crc;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_b;
  logic [DATA_W-1:0]   r_out_a;
  logic [2:0]          r_out_op;
  logic                r_err_valid;
  logic [2:0]          r_err_flags;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT_HIGH;
      r_is_cmd    <= 1'b0;
      r_bitcnt    <= '0;
      r_byte      <= '0;
      r_sh        <= '0;
      r_cnt       <= '0;
      r_crc       <= '0;
      r_out_valid <= 1'b0;
      r_out_b     <= '0;
      r_out_a     <= '0;
      r_out_op    <= '0;
      r_err_valid <= 1'b0;
      r_err_flags <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_err_valid <= 1'b0;
      case (r_state)
        S_WAIT_HIGH: if (bus.sin) r_state <= S_IDLE;
        S_IDLE:      if (!bus.sin) r_state <= S_TYPE;
        S_TYPE: begin
          r_is_cmd <= bus.sin;
          r_bitcnt <= '0;
          r_state  <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          r_byte   <= {r_byte[6:0], bus.sin};
          r_bitcnt <= r_bitcnt + 3'd1;
          // CMD leading payload bit is replaced by a constant 1 in the CRC; received CRC bits are not folded in
          if (!r_is_cmd)
            r_crc <= crc_step(r_crc, bus.sin);
          else if (r_bitcnt == 3'd0)
            r_crc <= crc_step(r_crc, 1'b1);
          else if (r_bitcnt <= 3'd3)
            r_crc <= crc_step(r_crc, bus.sin);
          if (r_bitcnt == 3'd7) r_state <= S_STOP;
        end
        S_STOP: begin
          if (!bus.sin) begin
            r_err_valid <= 1'b1;
            r_err_flags <= 3'b100;
            r_cnt       <= '0;
            r_crc       <= '0;
            r_state     <= S_WAIT_HIGH;
          end else if (!r_is_cmd) begin
            r_sh <= {r_sh[2*DATA_W-9:0], r_byte};
            if (r_cnt != CW'(NF + 1)) r_cnt <= r_cnt + 1'b1;
            r_state <= S_IDLE;
          end else begin
            if (r_cnt != CW'(NF)) begin
              r_err_valid <= 1'b1;
              r_err_flags <= 3'b100;
            end else if (r_crc != r_byte[3:0]) begin
              r_err_valid <= 1'b1;
              r_err_flags <= 3'b010;
            end else if (r_byte[5]) begin
              // Legal opcodes 000/001/100/101 are exactly those with OP[1]=0
              r_err_valid <= 1'b1;
              r_err_flags <= 3'b001;
            end else begin
              r_out_valid <= 1'b1;
              r_out_b     <= r_sh[2*DATA_W-1:DATA_W];
              r_out_a     <= r_sh[DATA_W-1:0];
              r_out_op    <= r_byte[6:4];
            end
            r_cnt   <= '0;
            r_crc   <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_WAIT_HIGH;
      endcase
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_b     = r_out_b;
  assign bus.out_a     = r_out_a;
  assign bus.out_op    = r_out_op;
  assign bus.err_valid = r_err_valid;
  assign bus.err_flags = r_err_flags;
endmodule

// File: tb/tb_alu_sin_deserializer.sv
// Directed bench for alu_sin_deserializer: hand-built packets with bench-side CRC model.
module tb_alu_sin_deserializer;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_sin_deserializer_if #(.DATA_W(DATA_W)) u_if ();

  alu_sin_deserializer #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bit per cycle; sin changes 1ns after the edge so the next edge samples it cleanly.
  task automatic send_bit(input logic b);
    u_if.sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stopb);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(pay[i]);
    send_bit(stopb);
  endtask

  task automatic send_data(input logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) send_frame(1'b0, d[63-8*i -: 8], 1'b1);
  endtask

  function automatic logic [3:0] mcrc(input logic [63:0] d, input int n, input logic [2:0] op);
    logic [3:0] c;
    logic [3:0] t;
    logic       fb;
    c = '0;
    t = {1'b1, op};
    for (int i = 0; i < n * 8; i++) begin
      fb = c[3] ^ d[63-i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    for (int i = 3; i >= 0; i--) begin
      fb = c[3] ^ t[i];
      c  = {c[2], c[1], c[0] ^ fb, fb};
    end
    return c;
  endfunction

  task automatic send_packet(input logic [31:0] b, input logic [31:0] a, input logic [2:0] op);
    send_data({b, a}, 8);
    send_frame(1'b1, {1'b0, op, mcrc({b, a}, 8, op)}, 1'b1);
  endtask

  task automatic expect_valid(input string tag, input logic [31:0] b, input logic [31:0] a,
                              input logic [2:0] op);
    check({tag, ".valid"}, 64'(u_if.out_valid), 64'd1);
    check({tag, ".errv"},  64'(u_if.err_valid), 64'd0);
    check({tag, ".b"},     64'(u_if.out_b), 64'(b));
    check({tag, ".a"},     64'(u_if.out_a), 64'(a));
    check({tag, ".op"},    64'(u_if.out_op), 64'(op));
    send_bit(1'b1);
    check({tag, ".pulse"}, 64'(u_if.out_valid), 64'd0);
  endtask

  task automatic expect_err(input string tag, input logic [2:0] flags);
    check({tag, ".errv"},  64'(u_if.err_valid), 64'd1);
    check({tag, ".valid"}, 64'(u_if.out_valid), 64'd0);
    check({tag, ".flags"}, 64'(u_if.err_flags), 64'(flags));
    send_bit(1'b1);
    check({tag, ".pulse"}, 64'(u_if.err_valid), 64'd0);
    check({tag, ".hold"},  64'(u_if.err_flags), 64'(flags));
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    u_if.sin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 64'(u_if.out_valid), 64'd0);
    check("rst.errv",  64'(u_if.err_valid), 64'd0);
    check("rst.flags", 64'(u_if.err_flags), 64'd0);
    check("rst.b",     64'(u_if.out_b), 64'd0);
    rst = 1'b0;
    send_bit(1'b1);

    // All-zero packet with hand-computed CRC 0xB
    send_data(64'd0, 8);
    send_frame(1'b1, {1'b0, 3'b000, 4'hB}, 1'b1);
    expect_valid("zero", 32'h0, 32'h0, 3'b000);

    send_packet(32'h12345678, 32'h9ABCDEF0, 3'b100);
    expect_valid("p1234", 32'h12345678, 32'h9ABCDEF0, 3'b100);

    // Bad CRC must leave the previously decoded operands untouched
    send_data(64'd0, 8);
    send_frame(1'b1, {1'b0, 3'b000, 4'hA}, 1'b1);
    expect_err("crc", 3'b010);
    check("crc.b",  64'(u_if.out_b), 64'h12345678);
    check("crc.a",  64'(u_if.out_a), 64'h9ABCDEF0);
    check("crc.op", 64'(u_if.out_op), 64'd4);

    send_data(64'h1122334455667788, 7);
    send_frame(1'b1, {1'b0, 3'b000, mcrc(64'h1122334455667788, 7, 3'b000)}, 1'b1);
    expect_err("short", 3'b100);
    send_packet(32'hDEADBEEF, 32'h01020304, 3'b001);
    expect_valid("after_short", 32'hDEADBEEF, 32'h01020304, 3'b001);

    send_data(64'hA5A5A5A5A5A5A5A5, 8);
    send_data(64'hFF00000000000000, 1);
    send_frame(1'b1, {1'b0, 3'b000, mcrc(64'hA5A5A5A5A5A5A5A5, 8, 3'b000)}, 1'b1);
    expect_err("long", 3'b100);

    send_packet(32'h0, 32'h0, 3'b010);
    expect_err("badop", 3'b001);

    send_data(64'h0102030405060708, 2);
    send_frame(1'b0, 8'h03, 1'b0);
    expect_err("frame", 3'b100);
    send_bit(1'b1);
    send_bit(1'b1);
    send_packet(32'hCAFEF00D, 32'h55AA33CC, 3'b101);
    expect_valid("after_frame", 32'hCAFEF00D, 32'h55AA33CC, 3'b101);

    // Reset in the payload of the 5th frame, sin held low across and after it
    send_data(64'h8877665544332211, 4);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst = 1'b1;
    u_if.sin = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mrst.b",     64'(u_if.out_b), 64'd0);
    check("mrst.a",     64'(u_if.out_a), 64'd0);
    check("mrst.op",    64'(u_if.out_op), 64'd0);
    check("mrst.flags", 64'(u_if.err_flags), 64'd0);
    repeat (12) send_bit(1'b0);
    check("mrst.novalid", 64'(u_if.out_valid), 64'd0);
    check("mrst.noerr",   64'(u_if.err_valid), 64'd0);
    send_bit(1'b1);
    send_packet(32'h0BADC0DE, 32'h76543210, 3'b000);
    expect_valid("after_rst", 32'h0BADC0DE, 32'h76543210, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sin_deserializer.md
Name: alu_sin_deserializer

Overview:
- Serial front-end of the ALU, directly upstream of the ALU core.
- Receives the `sin` bitstream: one bit per clk, idle high.
- Assembles operand frames B and A plus a command frame. Checks the frame count, the CRC4 and the opcode.
- Presents either a validated operand/opcode set or an error code to the core as a one-cycle pulse.

Parameters:
- DATA_W, 32: operand width in bits. Must be a multiple of 8. Data frames per packet = 2*DATA_W/8 (8 at default).

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous reset, active-high
- sin  in  1  serial input; idle 1
- out_valid  out  1  one-cycle pulse: valid packet decoded
- out_b  out  DATA_W  operand B (first DATA_W/8 data frames, MSB byte first)
- out_a  out  DATA_W  operand A (next DATA_W/8 data frames)
- out_op  out  3  opcode from the command frame
- err_valid  out  1  one-cycle pulse: packet rejected
- err_flags  out  3  {ERR_DATA, ERR_CRC, ERR_OP}; exactly one bit set when err_valid=1

Behaviour:
- Frame format, 11 bits, sampled one per posedge:
  - start bit = 0
  - type bit: 0 = DATA, 1 = CMD
  - 8 payload bits, MSB first
  - stop bit = 1
- CMD payload = {1'b0, OP[2:0], CRC[3:0]}.
- Reset:
  - out_valid=0, err_valid=0, err_flags=0, out_a=0, out_b=0, out_op=0.
  - Frame counter=0, CRC register=0, state=WAIT_HIGH.
  - Reset mid-frame discards all partial data.
- State machine:
  - WAIT_HIGH: go to IDLE when sin=1 is sampled.
  - IDLE: go to TYPE when sin=0 is sampled (start bit).
  - TYPE: latch the type bit, clear the bit counter, go to PAYLOAD.
  - PAYLOAD: shift in 8 bits; after the 8th, go to STOP.
  - STOP, sin=1, DATA frame: shift the byte into the 2*DATA_W operand shift register, increment the frame counter (saturate at 2*DATA_W/8+1), go to IDLE.
  - STOP, sin=1, CMD frame: evaluate the packet (see below), clear the frame counter and CRC, go to IDLE.
  - STOP, sin=0 (framing error): pulse err_valid with ERR_DATA, clear the frame counter and CRC, go to WAIT_HIGH.
- CRC4:
  - Polynomial x^4+x+1, init 0, computed serially MSB first over {B, A, 1'b1, OP} (2*DATA_W+4 bits).
  - Per bit d: fb = c[3]^d; c <= {c[2], c[1], c[0]^fb, fb}.
  - Updated on data payload bits, and on the constant 1 plus OP bits of the CMD frame.
  - The received CRC bits are compared, not shifted in.
- Packet evaluation, in priority order:
  1. Frame counter != 2*DATA_W/8 -> ERR_DATA.
  2. Else computed CRC != received CRC -> ERR_CRC.
  3. Else OP not in {000, 001, 100, 101} -> ERR_OP.
  4. Else out_valid.
- Timing:
  - out_valid/err_valid are registered on the clock edge that samples the CMD stop bit and are high for exactly one cycle.
  - out_b/out_a/out_op update only on out_valid and hold until the next valid packet.
  - err_flags is updated with err_valid and holds.
  - out_valid and err_valid are never both 1.
- More than 8 DATA frames before a CMD: the counter saturates and the CMD yields ERR_DATA. A CMD with fewer than 8 DATA frames also yields ERR_DATA. Either case resynchronises to a fresh packet.
- Back-to-back packets: a start bit may be sampled on the clock after the stop bit; no idle gap required.
- No backpressure: the downstream core must accept each pulse.

Test Plan:
- Reset, then B=0, A=0, OP=000, CRC=0xB -> out_valid pulse 1 cycle after the CMD stop-bit edge; out_b=0, out_a=0, out_op=000, err_valid=0.
- Same packet with CRC=0xA -> err_valid=1, err_flags=3'b010; out_b/out_a/out_op unchanged.
- 7 DATA frames then a CMD with correct CRC for its bits -> err_flags=3'b100; a following correct 8+1 packet -> out_valid.
- B=0, A=0, OP=010 with correct CRC (computed by the bench model) -> err_flags=3'b001. B=0x12345678, A=0x9ABCDEF0, OP=100 with model CRC -> out_b=0x12345678, out_a=0x9ABCDEF0, out_op=100.
- Stop bit forced to 0 on the 3rd DATA frame -> immediate err_flags=3'b100; then sin held 1, next valid packet decodes correctly.
- rst asserted mid-payload of the 5th frame with sin=0 -> outputs 0, no pulse until sin has been 1; then a full valid packet decodes.
